// File: rtl/sma_rr_sched_if.sv
// Handshake bundle for sma_rr_sched: per-channel sample inputs and the tagged result stream.
// master = sample front-end / downstream consumer side, slave = scheduler.
interface sma_rr_sched_if #(
  parameter int CH_NUM = 4,
  parameter int DATA_W = 16,
  parameter int CH_W   = 2
);
  logic [CH_NUM-1:0]        in_valid;
  logic [CH_NUM*DATA_W-1:0] in_data;
  logic [CH_NUM-1:0]        in_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [CH_W-1:0]          out_ch;
  logic [DATA_W-1:0]        out_data;
  logic                     out_warm;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_ch, out_data, out_warm
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_ch, out_data, out_warm
  );
endinterface

// File: rtl/sma_rr_sched.sv
// Round-robin scheduler sharing one 4-tap signed moving-average engine across CH_NUM channels.
// Optional per-channel history flush port enabled by defining SMA_RR_SCHED_FLUSH_EN.
module sma_rr_sched #(
  parameter int CH_NUM = 4,
  parameter int DATA_W = 16,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
`ifdef SMA_RR_SCHED_FLUSH_EN
  input  logic [CH_NUM-1:0] flush,
`endif
  sma_rr_sched_if.slave     bus
);

  logic signed [DATA_W-1:0] h1 [CH_NUM];
  logic signed [DATA_W-1:0] h2 [CH_NUM];
  logic signed [DATA_W-1:0] h3 [CH_NUM];
  logic [1:0]               fill [CH_NUM];
  logic [CH_W-1:0]          rr;

  logic [CH_NUM-1:0]        fl;
  logic                     adv;
  logic                     gnt_any;
  logic [CH_W-1:0]          gnt;
  logic [CH_W-1:0]          ci;
  int unsigned              idx;
  logic signed [DATA_W-1:0] x, hg1, hg2, hg3;
  logic signed [DATA_W:0]   s1;
  logic signed [DATA_W+1:0] s;
  logic signed [DATA_W-1:0] res;
  logic                     warm;

`ifdef SMA_RR_SCHED_FLUSH_EN
  always_comb fl = flush;
`else
  always_comb fl = '0;
`endif

  always_comb begin
    adv     = !bus.out_valid || bus.out_ready;
    gnt     = '0;
    gnt_any = 1'b0;
    idx     = 0;
    ci      = '0;
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      idx = (32'(rr) + k) % CH_NUM;
      ci  = CH_W'(idx);
      if (!gnt_any && bus.in_valid[ci]) begin
        gnt_any = 1'b1;
        gnt     = ci;
      end
    end
    if (!adv || !rst) gnt_any = 1'b0;
  end

  always_comb begin
    bus.in_ready = '0;
    if (gnt_any) bus.in_ready[gnt] = 1'b1;
  end

  // A same-cycle flush zeroes the old history before it reaches the adder.
  always_comb begin
    x    = bus.in_data[gnt*DATA_W +: DATA_W];
    hg1  = fl[gnt] ? '0 : h1[gnt];
    hg2  = fl[gnt] ? '0 : h2[gnt];
    hg3  = fl[gnt] ? '0 : h3[gnt];
    warm = !fl[gnt] && (fill[gnt] == 2'd3);
    s1   = (DATA_W+1)'(x) + (DATA_W+1)'(hg1);
    s    = (DATA_W+2)'(s1) + ((DATA_W+2)'(hg2) + (DATA_W+2)'(hg3));
    // The mean of four samples always fits, so the low DATA_W bits of the
    // shifted sum equal {sign, low bits}.
    res  = DATA_W'(s >>> 2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr            <= '0;
      bus.out_valid <= 1'b0;
      bus.out_ch    <= '0;
      bus.out_data  <= '0;
      bus.out_warm  <= 1'b0;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        h1[i]   <= '0;
        h2[i]   <= '0;
        h3[i]   <= '0;
        fill[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        if (gnt_any && (gnt == CH_W'(i))) begin
          h1[i]   <= x;
          h2[i]   <= fl[i] ? '0 : h1[i];
          h3[i]   <= fl[i] ? '0 : h2[i];
          fill[i] <= fl[i] ? 2'd1 : ((fill[i] == 2'd3) ? 2'd3 : fill[i] + 2'd1);
        end else if (fl[i]) begin
          h1[i]   <= '0;
          h2[i]   <= '0;
          h3[i]   <= '0;
          fill[i] <= '0;
        end
      end
      if (gnt_any) begin
        rr            <= (gnt == CH_W'(CH_NUM-1)) ? '0 : gnt + 1'b1;
        bus.out_valid <= 1'b1;
        bus.out_ch    <= gnt;
        bus.out_data  <= res;
        bus.out_warm  <= warm;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sma_rr_sched.sv
// Scoreboard bench for sma_rr_sched: a history-list reference model predicts grants and results.
module tb_sma_rr_sched;
  localparam int CH = 4;
  localparam int DW = 16;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sma_rr_sched_if #(.CH_NUM(CH), .DATA_W(DW), .CH_W(CW)) bus ();
  logic [CH-1:0] flush;

  sma_rr_sched #(.CH_NUM(CH), .DATA_W(DW), .CH_W(CW)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef SMA_RR_SCHED_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus)
  );

  typedef struct {
    int ch;
    int data;
    int warm;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  // reference model: last samples per channel (newest first), count of real samples
  int   mh   [CH][3];
  int   mcnt [CH];
  int   mrr;
  int   mov;
  int   smp  [CH];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int fdiv4(input int v);
    int r;
    r = v % 4;
    if (r < 0) r += 4;
    return (v - r) / 4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      mcnt[i] = 0;
      for (int j = 0; j < 3; j++) mh[i][j] = 0;
    end
    mrr = 0;
    mov = 0;
  endtask

  task automatic do_cycle(input logic [CH-1:0] v, input bit r, input logic [CH-1:0] f);
    int g;
    int sum;
    int c;
    exp_t e;
    logic [CH-1:0] er;
    @(posedge clk);
    #1;
    bus.in_valid = v;
    for (int i = 0; i < CH; i++) bus.in_data[i*DW +: DW] = DW'(smp[i]);
    bus.out_ready = r;
    flush = f;
    @(negedge clk);
    g  = -1;
    er = '0;
    if (mov == 0 || r) begin
      for (int k = 0; k < CH; k++) begin
        c = (mrr + k) % CH;
        if (g < 0 && v[c]) g = c;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    check("in_ready", int'(bus.in_ready), int'(er));
    check("out_valid", int'(bus.out_valid), mov);
`ifdef SMA_RR_SCHED_FLUSH_EN
    for (int i = 0; i < CH; i++) if (f[i]) mcnt[i] = 0;
`endif
    if (g >= 0) begin
      sum = smp[g];
      for (int j = 0; j < mcnt[g]; j++) sum += mh[g][j];
      e.ch   = g;
      e.data = fdiv4(sum);
      e.warm = (mcnt[g] == 3) ? 1 : 0;
      sbq.push_back(e);
      mh[g][2] = mh[g][1];
      mh[g][1] = mh[g][0];
      mh[g][0] = smp[g];
      if (mcnt[g] < 3) mcnt[g]++;
      mrr = (g + 1) % CH;
      mov = 1;
    end else if (r) begin
      mov = 0;
    end
  endtask

  task automatic rand_samples();
    for (int i = 0; i < CH; i++) smp[i] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  task automatic one_ch(input int ch, input int val, input logic [CH-1:0] f);
    logic [CH-1:0] v;
    v = '0;
    v[ch] = 1'b1;
    smp[ch] = val;
    do_cycle(v, 1'b1, f);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_in_ready", int'(bus.in_ready), 0);
    sbq.delete();
    model_reset();
    bus.in_valid = '0;
    flush = '0;
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  // monitor: compares each delivered result and holds stalled results against the queue head
  always @(negedge clk) begin
    exp_t e;
    if (rst && bus.out_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=ch%0d/%0d required=none at %0t",
                 bus.out_ch, $signed(bus.out_data), $time);
      end else if (bus.out_ready) begin
        e = sbq.pop_front();
        check("out_ch", int'(bus.out_ch), e.ch);
        check("out_data", int'($signed(bus.out_data)), e.data);
        check("out_warm", int'(bus.out_warm), e.warm);
      end else begin
        check("stall_data", int'($signed(bus.out_data)), sbq[0].data);
        check("stall_ch", int'(bus.out_ch), sbq[0].ch);
      end
    end
  end

  initial begin
    logic [CH-1:0] f;
    bus.in_valid  = '1;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    flush         = '0;
    model_reset();
    for (int i = 0; i < CH; i++) smp[i] = 0;
    #2;
    check("reset_in_ready", int'(bus.in_ready), 0);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_out_ch", int'(bus.out_ch), 0);
    check("reset_out_data", int'(bus.out_data), 0);
    check("reset_out_warm", int'(bus.out_warm), 0);
    bus.in_valid = '0;
    #15;
    rst = 1'b1;

    // warm-up on channel 0
    one_ch(0, 4, '0);
    one_ch(0, 8, '0);
    one_ch(0, 12, '0);
    one_ch(0, 16, '0);
    do_cycle('0, 1'b1, '0);

    // strict rotation with all channels requesting
    for (int n = 0; n < 8; n++) begin
      rand_samples();
      do_cycle('1, 1'b1, '0);
    end
    do_cycle('0, 1'b1, '0);

    // extremes and floor rounding
    for (int n = 0; n < 4; n++) one_ch(2, -32768, '0);
    for (int n = 0; n < 4; n++) one_ch(1, 32767, '0);
    one_ch(3, -1, '0);
    one_ch(3, -1, '0);
    one_ch(3, -1, '0);
    one_ch(3, -2, '0);

    // backpressure: hold 5 cycles then resume at the saved pointer
    rand_samples();
    do_cycle('1, 1'b1, '0);
    for (int n = 0; n < 5; n++) begin
      rand_samples();
      do_cycle('1, 1'b0, '0);
    end
    for (int n = 0; n < 3; n++) begin
      rand_samples();
      do_cycle('1, 1'b1, '0);
    end

    // asynchronous reset mid-stream
    rand_samples();
    do_cycle('1, 1'b1, '0);
    async_reset();
    one_ch(0, 100, '0);
    do_cycle('0, 1'b1, '0);

`ifdef SMA_RR_SCHED_FLUSH_EN
    for (int n = 0; n < 4; n++) one_ch(1, 40, '0);
    one_ch(1, 40, 4'b0010);
    one_ch(1, 40, '0);
    do_cycle('0, 1'b1, '0);
`endif

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rand_samples();
      f = '0;
`ifdef SMA_RR_SCHED_FLUSH_EN
      if ($urandom_range(0, 7) == 0) f = CH'($urandom);
`endif
      if (n % 100 < 20) do_cycle(4'b0100, $urandom_range(0, 3) != 0, f);
      else              do_cycle(CH'($urandom), $urandom_range(0, 3) != 0, f);
    end

    for (int n = 0; n < 3; n++) do_cycle('0, 1'b1, '0);
    check("scoreboard_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
